// File: rtl/gcc_seq_ctrl.sv
// AXI4-Lite controlled run/pause/oneshot sequence counter with registered Gray-code output.
// Commands written to CTRL act on the same clock edge that completes the write handshake.
module gcc_seq_ctrl #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int CNT_WIDTH          = 8
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  input  logic                            TICK_I,
  output logic [CNT_WIDTH-1:0]            GRAY_O,
  output logic                            WRAP_O,
  output logic                            DONE_O
);
  localparam int DW = C_S_AXI_DATA_WIDTH;

  typedef enum logic [1:0] {S_IDLE = 2'b00, S_RUN = 2'b01, S_PAUSE = 2'b10, S_DONE = 2'b11} state_t;

  state_t               state, state_nxt;
  logic [CNT_WIDTH-1:0] count, count_nxt, term, gray_q;
  logic                 oneshot, wrapped, wrap_ev, wrap_q;
  logic                 awready, bvalid, arready, rvalid;
  logic [DW-1:0]        rdata, rd_mux, wmask;
  logic [63:0]          status_w;
  logic                 wr_en, rd_en, ctrl_wr, term_wr;
  logic                 cmd_clear, cmd_stop, cmd_start;

  for (genvar b = 0; b < DW/8; b++) begin : g_strb
    assign wmask[b*8 +: 8] = {8{S_AXI_WSTRB[b]}};
  end

  assign wr_en   = awready & S_AXI_AWVALID & S_AXI_WVALID;
  assign rd_en   = arready & S_AXI_ARVALID;
  assign ctrl_wr = wr_en && (S_AXI_AWADDR[3:2] == 2'd0) && S_AXI_WSTRB[0];
  assign term_wr = wr_en && (S_AXI_AWADDR[3:2] == 2'd1);

  // One command per write, CLEAR > STOP > START
  assign cmd_clear = ctrl_wr & S_AXI_WDATA[2];
  assign cmd_stop  = ctrl_wr & S_AXI_WDATA[1] & ~S_AXI_WDATA[2];
  assign cmd_start = ctrl_wr & S_AXI_WDATA[0] & ~S_AXI_WDATA[1] & ~S_AXI_WDATA[2];

  // AXI handshakes: one accept per response, response held until taken
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      awready <= 1'b0;
      bvalid  <= 1'b0;
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rdata   <= '0;
    end else begin
      awready <= S_AXI_AWVALID & S_AXI_WVALID & ~awready & ~bvalid;
      if (wr_en)             bvalid <= 1'b1;
      else if (S_AXI_BREADY) bvalid <= 1'b0;
      arready <= S_AXI_ARVALID & ~arready & ~rvalid;
      if (rd_en) begin
        rvalid <= 1'b1;
        rdata  <= rd_mux;
      end else if (S_AXI_RREADY) begin
        rvalid <= 1'b0;
      end
    end
  end

  assign S_AXI_AWREADY = awready;
  assign S_AXI_WREADY  = awready;
  assign S_AXI_BVALID  = bvalid;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_ARREADY = arready;
  assign S_AXI_RVALID  = rvalid;
  assign S_AXI_RDATA   = rdata;
  assign S_AXI_RRESP   = 2'b00;

  // Read mux samples pre-write contents: register writes land on the same edge
  always_comb begin
    status_w = {{(56-CNT_WIDTH){1'b0}}, count, 5'b0, wrapped, state};
    rd_mux   = '0;
    case (S_AXI_ARADDR[3:2])
      2'd0:    rd_mux[3] = oneshot;
      2'd1:    rd_mux[CNT_WIDTH-1:0] = term;
      2'd2:    rd_mux[CNT_WIDTH-1:0] = gray_q;
      default: rd_mux = status_w[31:0];
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      oneshot <= 1'b0;
      term    <= '1;
    end else begin
      if (ctrl_wr) oneshot <= S_AXI_WDATA[3];
      if (term_wr) term <= (term & ~wmask[CNT_WIDTH-1:0]) |
                           (S_AXI_WDATA[CNT_WIDTH-1:0] & wmask[CNT_WIDTH-1:0]);
    end
  end

  // FSM state register, including the count datapath it owns
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state   <= S_IDLE;
      count   <= '0;
      wrapped <= 1'b0;
      wrap_q  <= 1'b0;
      gray_q  <= '0;
    end else begin
      state  <= state_nxt;
      count  <= count_nxt;
      wrap_q <= wrap_ev;
      gray_q <= count ^ (count >> 1);
      if (cmd_clear)    wrapped <= 1'b0;
      else if (wrap_ev) wrapped <= 1'b1;
    end
  end

  // Next state; a TERM below the count is only met after binary rollover
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    wrap_ev   = 1'b0;
    if (cmd_clear) begin
      state_nxt = S_IDLE;
      count_nxt = '0;
    end else if (cmd_stop) begin
      if (state == S_RUN) state_nxt = S_PAUSE;
    end else if (cmd_start && state != S_RUN) begin
      state_nxt = S_RUN;
      if (state == S_DONE) count_nxt = '0;
    end else if (state == S_RUN && TICK_I) begin
      if (count == term) begin
        if (oneshot) state_nxt = S_DONE;
        else begin
          count_nxt = '0;
          wrap_ev   = 1'b1;
        end
      end else begin
        count_nxt = count + CNT_WIDTH'(1);
        wrap_ev   = &count;
      end
    end
  end

  always_comb begin
    DONE_O = (state == S_DONE);
    WRAP_O = wrap_q;
    GRAY_O = gray_q;
  end

  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR,
                       S_AXI_WDATA, wmask, status_w[63:32]};
endmodule

// File: tb/tb_gcc_seq_ctrl.sv
// Directed bench for gcc_seq_ctrl: cycle model of the counter plus literal spot checks.
module tb_gcc_seq_ctrl;
  localparam int CW = 8;
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, DONE = 2'd3;

  logic        ACLK, ARESET;
  logic [3:0]  S_AXI_AWADDR, S_AXI_ARADDR, S_AXI_WSTRB;
  logic [2:0]  S_AXI_AWPROT, S_AXI_ARPROT;
  logic        S_AXI_AWVALID, S_AXI_AWREADY, S_AXI_WVALID, S_AXI_WREADY;
  logic [31:0] S_AXI_WDATA, S_AXI_RDATA;
  logic [1:0]  S_AXI_BRESP, S_AXI_RRESP;
  logic        S_AXI_BVALID, S_AXI_BREADY, S_AXI_ARVALID, S_AXI_ARREADY;
  logic        S_AXI_RVALID, S_AXI_RREADY, TICK_I, WRAP_O, DONE_O;
  logic [CW-1:0] GRAY_O;

  gcc_seq_ctrl #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4), .CNT_WIDTH(CW)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT), .S_AXI_AWVALID(S_AXI_AWVALID),
    .S_AXI_AWREADY(S_AXI_AWREADY), .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_BRESP(S_AXI_BRESP),
    .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_ARADDR(S_AXI_ARADDR),
    .S_AXI_ARPROT(S_AXI_ARPROT), .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP), .S_AXI_RVALID(S_AXI_RVALID),
    .S_AXI_RREADY(S_AXI_RREADY), .TICK_I(TICK_I), .GRAY_O(GRAY_O), .WRAP_O(WRAP_O), .DONE_O(DONE_O)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int n_pass = 0, n_tot = 0;
  bit chk_on = 1'b0;

  // Model of the programmer-visible state; a write is handed over by the master side
  logic [1:0]  m_st;
  logic [7:0]  m_cnt, m_term, m_gray;
  logic        m_os, m_wrp, m_wrapo;
  int          wr_req = 0, wr_ack = 0;
  logic [3:0]  wr_a, wr_s;
  logic [31:0] wr_d;

  always @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      m_st = IDLE; m_cnt = 0; m_term = 8'hFF; m_os = 0; m_wrp = 0; m_gray = 0; m_wrapo = 0;
      wr_ack = wr_req;
    end else begin
      logic clr, stp, sta, ev, adv, pend;
      pend = (wr_req != wr_ack);
      clr = 0; stp = 0; sta = 0; ev = 0;
      if (pend && wr_a[3:2] == 2'd0 && wr_s[0]) begin
        clr = wr_d[2]; stp = wr_d[1]; sta = wr_d[0];
      end
      m_gray = m_cnt ^ (m_cnt >> 1);
      adv = TICK_I && m_st == RUN;
      if (clr) begin
        m_st = IDLE; m_cnt = 0; m_wrp = 0; adv = 0;
      end else if (stp) begin
        if (m_st == RUN) m_st = PAUSE;
        adv = 0;
      end else if (sta && m_st != RUN) begin
        if (m_st == DONE) m_cnt = 0;
        m_st = RUN; adv = 0;
      end
      if (adv) begin
        if (m_cnt == m_term) begin
          if (m_os) m_st = DONE;
          else begin m_cnt = 0; ev = 1; end
        end else begin
          ev = (m_cnt == 8'hFF);
          m_cnt = m_cnt + 8'd1;
        end
      end
      if (ev) m_wrp = 1;
      m_wrapo = ev;
      if (pend) begin
        if (wr_a[3:2] == 2'd0 && wr_s[0]) m_os = wr_d[3];
        if (wr_a[3:2] == 2'd1 && wr_s[0]) m_term = wr_d[7:0];
        wr_ack = wr_ack + 1;
      end
    end
  end

  function automatic logic [31:0] m_read(input logic [3:0] a);
    case (a[3:2])
      2'd0:    return {28'd0, m_os, 3'd0};
      2'd1:    return {24'd0, m_term};
      2'd2:    return {24'd0, m_gray};
      default: return {16'd0, m_cnt, 5'd0, m_wrp, m_st};
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    else n_pass++;
  endtask

  task automatic post_wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    wr_a = a; wr_d = d; wr_s = s; wr_req = wr_req + 1;
  endtask

  task automatic axi_wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    bit got = 0;
    S_AXI_AWADDR = a; S_AXI_WDATA = d; S_AXI_WSTRB = s;
    S_AXI_AWVALID = 1; S_AXI_WVALID = 1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge ACLK);
      if (S_AXI_AWREADY) begin
        got = 1;
        chk("wready_with_awready", S_AXI_WREADY, 1);
        post_wr(a, d, s);
      end
    end
    chk("aw_accept", got, 1);
    @(negedge ACLK);
    S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
    chk("bvalid", S_AXI_BVALID, 1);
    chk("bresp", S_AXI_BRESP, 0);
    @(negedge ACLK);
  endtask

  task automatic axi_rd(input logic [3:0] a, output logic [31:0] d);
    bit got = 0;
    logic [31:0] e = 0;
    S_AXI_ARADDR = a; S_AXI_ARVALID = 1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge ACLK);
      if (S_AXI_ARREADY) begin got = 1; e = m_read(a); end
    end
    chk("ar_accept", got, 1);
    @(negedge ACLK);
    S_AXI_ARVALID = 0;
    chk("rvalid", S_AXI_RVALID, 1);
    chk("rresp", S_AXI_RRESP, 0);
    chk("rdata_model", S_AXI_RDATA, e);
    d = S_AXI_RDATA;
    @(negedge ACLK);
  endtask

  task automatic ticks(input int n);
    TICK_I = 1;
    repeat (n) @(negedge ACLK);
    TICK_I = 0;
  endtask

  initial begin
    logic [31:0] rd;
    logic [7:0]  g [9];
    logic [7:0]  gnext [4] = '{8'd1, 8'd3, 8'd0, 8'd2};
    int          wraps;
    bit          got;
    ARESET = 0; TICK_I = 0;
    S_AXI_AWADDR = 0; S_AXI_AWPROT = 0; S_AXI_AWVALID = 0; S_AXI_WDATA = 0; S_AXI_WSTRB = 0;
    S_AXI_WVALID = 0; S_AXI_BREADY = 1; S_AXI_ARADDR = 0; S_AXI_ARPROT = 0; S_AXI_ARVALID = 0;
    S_AXI_RREADY = 1;
    #1 ARESET = 1;
    repeat (3) @(negedge ACLK);
    chk("rst_gray", GRAY_O, 0);
    chk("rst_wrap", WRAP_O, 0);
    chk("rst_done", DONE_O, 0);
    chk("rst_ready", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 0);
    chk("rst_valid", {S_AXI_BVALID, S_AXI_RVALID}, 0);
    chk("rst_rdata", S_AXI_RDATA, 0);
    ARESET = 0;
    chk_on = 1;

    fork
      forever begin
        @(negedge ACLK);
        if (chk_on && !ARESET) begin
          chk("cyc_gray", GRAY_O, m_gray);
          chk("cyc_wrap", WRAP_O, m_wrapo);
          chk("cyc_done", DONE_O, m_st == DONE);
        end
      end
    join_none

    @(negedge ACLK);
    axi_rd(4'h4, rd);  chk("rst_term", rd, 32'hFF);
    axi_rd(4'hC, rd);  chk("rst_status", rd, 0);

    // Wrap mode, TERM=3: Gray walks 0,1,3,2 and wraps every 4 ticks
    axi_wr(4'h4, 32'h3, 4'hF);
    axi_wr(4'h0, 32'h1, 4'hF);
    TICK_I = 1;
    repeat (2) @(negedge ACLK);
    wraps = 0;
    for (int k = 0; k < 9; k++) begin
      g[k] = GRAY_O;
      if (k < 8) wraps += int'(WRAP_O);
      @(negedge ACLK);
    end
    TICK_I = 0;
    for (int k = 0; k < 8; k++) chk("gray_seq", g[k+1], gnext[g[k][1:0]]);
    chk("wrap_pulses_8", wraps, 2);
    axi_rd(4'hC, rd);  chk("wrapped_run", rd[2:0], 3'b101);
    axi_wr(4'h4, 32'h0000_0000, 4'b0010);
    axi_rd(4'h4, rd);  chk("term_strb_masked", rd, 32'h3);

    // Oneshot to TERM=5, then restart from DONE
    axi_wr(4'h0, 32'h4, 4'hF);
    axi_wr(4'h4, 32'h5, 4'hF);
    axi_wr(4'h0, 32'h9, 4'hF);
    ticks(10);
    axi_rd(4'hC, rd);  chk("oneshot_status", rd, 32'h0503);
    chk("oneshot_gray", GRAY_O, 8'h07);
    chk("oneshot_done", DONE_O, 1);
    axi_rd(4'h0, rd);  chk("ctrl_read", rd, 32'h8);
    axi_wr(4'h0, 32'h9, 4'hF);
    axi_rd(4'hC, rd);  chk("restart_from_done", rd, 32'h0001);

    // Pause holds count against ticks, START resumes
    axi_wr(4'h0, 32'h4, 4'hF);
    axi_wr(4'h4, 32'hFF, 4'hF);
    axi_wr(4'h0, 32'h1, 4'hF);
    ticks(2);
    axi_wr(4'h0, 32'h2, 4'hF);
    ticks(10);
    axi_rd(4'hC, rd);  chk("pause_status", rd, 32'h0202);
    axi_wr(4'h0, 32'h1, 4'hF);
    ticks(3);
    axi_rd(4'hC, rd);  chk("resume_status", rd, 32'h0501);

    // TERM below count: rollover at 255 first, then TERM=0 wraps every tick
    axi_wr(4'h4, 32'h0, 4'hF);
    ticks(253);
    axi_rd(4'hC, rd);  chk("rollover_status", rd, 32'h0005);
    TICK_I = 1;
    wraps = 0;
    repeat (4) begin @(negedge ACLK); wraps += int'(WRAP_O); end
    TICK_I = 0;
    chk("term0_wrap_each", wraps, 4);
    axi_wr(4'h0, 32'h7, 4'hF);
    axi_rd(4'hC, rd);  chk("clear_priority", rd, 32'h0);
    chk("clear_gray", GRAY_O, 0);

    // Early AWVALID, slow BREADY, back-to-back write held off
    S_AXI_BREADY = 0;
    S_AXI_AWADDR = 4'h4; S_AXI_WDATA = 32'h44; S_AXI_WSTRB = 4'hF; S_AXI_AWVALID = 1;
    repeat (3) begin @(negedge ACLK); chk("aw_early", S_AXI_AWREADY, 0); end
    S_AXI_WVALID = 1;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge ACLK);
      if (S_AXI_AWREADY) begin got = 1; post_wr(4'h4, 32'h44, 4'hF); end
    end
    chk("aw_accept_late_w", got, 1);
    @(negedge ACLK);
    S_AXI_AWADDR = 4'h8; S_AXI_WDATA = 32'hFFFF_FFFF;
    repeat (5) begin
      chk("bvalid_hold", S_AXI_BVALID, 1);
      chk("no_second_accept", S_AXI_AWREADY, 0);
      @(negedge ACLK);
    end
    S_AXI_BREADY = 1;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge ACLK);
      if (S_AXI_AWREADY) begin got = 1; post_wr(4'h8, 32'hFFFF_FFFF, 4'hF); end
    end
    chk("second_accept", got, 1);
    @(negedge ACLK);
    S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
    chk("ro_write_bresp", {S_AXI_BVALID, S_AXI_BRESP}, 3'b100);
    @(negedge ACLK);
    axi_rd(4'h4, rd);  chk("term_after_slow_b", rd, 32'h44);
    axi_rd(4'h8, rd);  chk("gray_ro", rd, 32'h0);

    // Reset while a write response is pending
    S_AXI_BREADY = 0;
    S_AXI_AWADDR = 4'h4; S_AXI_WDATA = 32'h12; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1; S_AXI_WVALID = 1;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge ACLK);
      if (S_AXI_AWREADY) begin got = 1; post_wr(4'h4, 32'h12, 4'hF); end
    end
    chk("rst_wr_accept", got, 1);
    @(negedge ACLK);
    S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
    chk("bvalid_pre_rst", S_AXI_BVALID, 1);
    #2 ARESET = 1;
    #1 chk("bvalid_async_clr", S_AXI_BVALID, 0);
    @(negedge ACLK);
    ARESET = 0; S_AXI_BREADY = 1;
    @(negedge ACLK);
    axi_rd(4'h4, rd);  chk("term_after_rst", rd, 32'hFF);
    axi_rd(4'hC, rd);  chk("status_after_rst", rd, 32'h0);

    repeat (2) @(negedge ACLK);
    chk_on = 0;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
